maze_path_checker: RTL and testbench

// Downstream consumer of the maze solver's 8-bit move stream. Buffers each reported cell in a FIFO,

---
 rtl/maze_path_checker.sv | 181 ++++++++++++++++++
 tb/tb_maze_path_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_path_checker.sv
// Path checker for the maze solver's move stream: buffers, validates and replays path cells.
// Define MAZE_REVISIT_CHECK_EN to add a 256-cell visited bitmap that flags revisits (err 6).
module maze_path_checker #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [7:0]  START_RC = 8'h00,
    parameter logic [7:0]  GOAL_RC  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] move,
    input  logic       solv_done,
    input  logic       solv_fail,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_rc,
    output logic [8:0] path_len,
    output logic       busy,
    output logic       pass,
    output logic [2:0] err
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_STEP    = 3'd2;
    localparam logic [2:0] ERR_OVF     = 3'd3;
    localparam logic [2:0] ERR_FAIL    = 3'd4;
    localparam logic [2:0] ERR_GOAL    = 3'd5;
    localparam logic [2:0] ERR_REVISIT = 3'd6;
    localparam logic [2:0] ERR_EMPTY   = 3'd7;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StReport} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      prev_q;
    logic [8:0]      path_len_q;
    logic [2:0]      err_q, err_d;
    logic            pass_q, pass_d;

    logic            collecting, push_req, push, pop, full, overflow, finish, revisit;
    logic [7:0]      last_rc;
    logic [2:0]      cell_err, done_err;

    // Manhattan distance of exactly one; 4-bit coordinates never wrap.
    function automatic logic is_adjacent(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] dr, dc;
        logic [4:0] sum;
        dr  = (a[7:4] > b[7:4]) ? a[7:4] - b[7:4] : b[7:4] - a[7:4];
        dc  = (a[3:0] > b[3:0]) ? a[3:0] - b[3:0] : b[3:0] - a[3:0];
        sum = {1'b0, dr} + {1'b0, dc};
        return sum == 5'd1;
    endfunction

`ifdef MAZE_REVISIT_CHECK_EN
    logic [255:0] visited_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            visited_q <= '0;
        end else if (start) begin
            visited_q <= '0;
        end else if (push_req) begin
            visited_q[move] <= 1'b1;
        end
    end

    assign revisit = visited_q[move];
`else
    assign revisit = 1'b0;
`endif

    always_comb begin
        collecting = (state_q == StCollect) && !start;
        push_req   = collecting && in_valid;
        pop        = out_valid && out_ready;
        full       = (count_q == FULL_CNT);
        push       = push_req && (!full || pop);
        overflow   = push_req && full && !pop;
        finish     = collecting && (solv_done || solv_fail);
        last_rc    = push_req ? move : prev_q;

        cell_err = '0;
        if (push_req) begin
            if (path_len_q == '0) begin
                if (move != START_RC) cell_err = ERR_START;
            end else if (!is_adjacent(prev_q, move)) begin
                cell_err = ERR_STEP;
            end
            if (cell_err == '0) begin
                if (overflow)     cell_err = ERR_OVF;
                else if (revisit) cell_err = ERR_REVISIT;
            end
        end

        done_err = '0;
        if (finish) begin
            if (solv_fail)                          done_err = ERR_FAIL;
            else if (path_len_q == '0 && !push_req) done_err = ERR_EMPTY;
            else if (last_rc != GOAL_RC)            done_err = ERR_GOAL;
        end

        // The cell arriving with done is judged before the end-of-path checks.
        err_d = err_q;
        if (err_q == '0) err_d = (cell_err != '0) ? cell_err : done_err;

        state_d = state_q;
        pass_d  = pass_q;
        if (start) begin
            state_d = StCollect;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StCollect: if (solv_done || solv_fail) state_d = StDrain;
                StDrain: begin
                    if (count_q == '0) begin
                        state_d = StReport;
                        pass_d  = (err_q == '0);
                    end
                end
                StReport:  state_d = StReport;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            path_len_q <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
        end else if (start) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            path_len_q <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (push_req) begin
                prev_q <= move;
                if (path_len_q != 9'h1FF) path_len_q <= path_len_q + 1'b1;
            end
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= move;
    end

    assign out_valid = (count_q != '0);
    assign out_rc    = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign path_len  = path_len_q;
    assign busy      = (state_q == StCollect) || (state_q == StDrain);
    assign pass      = pass_q;
    assign err       = err_q;

endmodule

// File: tb/tb_maze_path_checker.sv
// Directed bench for maze_path_checker: legal paths, each error code, FIFO overflow and replay.
module tb_maze_path_checker;
    localparam int unsigned DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] move = 8'h00;
    logic       solv_done = 1'b0;
    logic       solv_fail = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_rc;
    logic [8:0] path_len;
    logic       busy;
    logic       pass;
    logic [2:0] err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] popped [$];
    logic [7:0] stair [$];

    maze_path_checker #(
        .DEPTH   (DEPTH),
        .START_RC(8'h00),
        .GOAL_RC (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .move     (move),
        .solv_done(solv_done),
        .solv_fail(solv_fail),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_rc   (out_rc),
        .path_len (path_len),
        .busy     (busy),
        .pass     (pass),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Handshake values are stable at the falling edge, so a pop is recorded there.
    always @(negedge clk) begin
        if (out_valid && out_ready) popped.push_back(out_rc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        popped.delete();
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        move     = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic end_path(input logic done, input logic fail);
        solv_done = done;
        solv_fail = fail;
        step();
        solv_done = 1'b0;
        solv_fail = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        check_eq({tag, "_reached_report"}, busy, 1'b0);
    endtask

    function automatic logic [7:0] snake(input int i);
        int r = i / 16;
        int c = (r % 2 == 0) ? (i % 16) : (15 - i % 16);
        return {r[3:0], c[3:0]};
    endfunction

    initial begin
        // Staircase 00,01,11,12,...,EF,FF: 31 cells.
        stair.push_back(8'h00);
        for (int k = 0; k < 15; k++) begin
            stair.push_back({stair[stair.size()-1][7:4], stair[stair.size()-1][3:0] + 4'd1});
            stair.push_back({stair[stair.size()-1][7:4] + 4'd1, stair[stair.size()-1][3:0]});
        end

        step();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_rc", out_rc, 8'h00);
        check_eq("rst_path_len", path_len, 9'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_err", err, 3'd0);
        rst = 1'b0;
        step();

        // Reset mid-collect with five cells buffered.
        do_start();
        check_eq("t1_busy_armed", busy, 1'b1);
        for (int i = 0; i < 5; i++) send(snake(i));
        check_eq("t1_len_before", path_len, 9'd5);
        check_eq("t1_valid_before", out_valid, 1'b1);
        rst = 1'b1;
        step();
        check_eq("t1_out_valid", out_valid, 1'b0);
        check_eq("t1_path_len", path_len, 9'd0);
        check_eq("t1_busy", busy, 1'b0);
        check_eq("t1_err", err, 3'd0);
        rst = 1'b0;
        step();

        // Legal staircase to goal with replay running.
        do_start();
        out_ready = 1'b1;
        foreach (stair[i]) send(stair[i]);
        end_path(1'b1, 1'b0);
        wait_report("t2");
        check_eq("t2_pop_count", popped.size(), 31);
        foreach (stair[i]) check_eq($sformatf("t2_pop%0d", i), popped[i], stair[i]);
        check_eq("t2_path_len", path_len, 9'd31);
        check_eq("t2_pass", pass, 1'b1);
        check_eq("t2_err", err, 3'd0);
        check_eq("t2_out_valid", out_valid, 1'b0);

        // Same path, final cell arriving together with done.
        do_start();
        for (int i = 0; i < 30; i++) send(stair[i]);
        in_valid  = 1'b1;
        move      = 8'hFF;
        solv_done = 1'b1;
        step();
        in_valid  = 1'b0;
        solv_done = 1'b0;
        wait_report("t2b");
        check_eq("t2b_path_len", path_len, 9'd31);
        check_eq("t2b_pass", pass, 1'b1);
        check_eq("t2b_err", err, 3'd0);

        // Bad start cell; later non-adjacent steps must not overwrite it.
        do_start();
        send(8'h10);
        check_eq("t3_err_first", err, 3'd1);
        send(8'h10);
        send(8'h12);
        end_path(1'b1, 1'b0);
        wait_report("t3");
        check_eq("t3_err", err, 3'd1);
        check_eq("t3_pass", pass, 1'b0);
        check_eq("t3_pop_count", popped.size(), 3);

        // Overflow: DEPTH+1 legal cells with the consumer stalled.
        do_start();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(snake(i));
        check_eq("t4_err_full", err, 3'd0);
        send(snake(DEPTH));
        check_eq("t4_err", err, 3'd3);
        check_eq("t4_out_valid", out_valid, 1'b1);
        check_eq("t4_path_len", path_len, 9'(DEPTH + 1));
        check_eq("t4_head", out_rc, 8'h00);
        step();
        check_eq("t4_head_held", out_rc, 8'h00);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (out_valid && n < 500) begin
                step();
                n++;
            end
        end
        check_eq("t4_drained", out_valid, 1'b0);
        check_eq("t4_pop_count", popped.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq($sformatf("t4_pop%0d", i), popped[i], snake(i));
        end
        end_path(1'b1, 1'b0);
        wait_report("t4");
        check_eq("t4_err_final", err, 3'd3);
        check_eq("t4_pass", pass, 1'b0);

        // Solver fail after two cells.
        do_start();
        send(8'h00);
        send(8'h01);
        end_path(1'b0, 1'b1);
        wait_report("t5");
        check_eq("t5_err", err, 3'd4);
        check_eq("t5_pass", pass, 1'b0);
        check_eq("t5_pop_count", popped.size(), 2);
        check_eq("t5_pop0", popped[0], 8'h00);
        check_eq("t5_pop1", popped[1], 8'h01);

        // Done and fail together count as fail.
        do_start();
        send(8'h00);
        end_path(1'b1, 1'b1);
        wait_report("t5b");
        check_eq("t5b_err", err, 3'd4);

        // Done with zero cells, then a stray cell in REPORT is ignored.
        do_start();
        end_path(1'b1, 1'b0);
        wait_report("t5c");
        check_eq("t5c_err", err, 3'd7);
        check_eq("t5c_pass", pass, 1'b0);
        send(8'h55);
        check_eq("t5c_len_ignored", path_len, 9'd0);
        check_eq("t5c_valid_ignored", out_valid, 1'b0);

        // Revisit 00,01,00 then goal never reached.
        do_start();
        send(8'h00);
        send(8'h01);
        send(8'h00);
`ifdef MAZE_REVISIT_CHECK_EN
        check_eq("t6_err_revisit", err, 3'd6);
`else
        check_eq("t6_err_revisit", err, 3'd0);
`endif
        end_path(1'b1, 1'b0);
        wait_report("t6");
`ifdef MAZE_REVISIT_CHECK_EN
        check_eq("t6_err", err, 3'd6);
`else
        check_eq("t6_err", err, 3'd5);
`endif
        check_eq("t6_pass", pass, 1'b0);
        check_eq("t6_path_len", path_len, 9'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
